// File: rtl/pipe_ifid_queue_if.sv
// IF->ID handshake bundle for pipe_ifid_queue.
// The bubble_cnt signal exists only when IFID_BUBBLE_CNT_EN is defined.
interface pipe_ifid_queue_if #(
    parameter int AW = 1
);
    logic        if_valid;
    logic [31:0] if_inst;
    logic [31:0] if_pc4;
    logic        if_ready;
    logic        flush;
    logic        id_ready;
    logic        id_valid;
    logic [31:0] id_inst;
    logic [31:0] id_pc4;
    logic [AW:0] count;
`ifdef IFID_BUBBLE_CNT_EN
    logic [31:0] bubble_cnt;

    modport slave (
        input  if_valid, if_inst, if_pc4, flush, id_ready,
        output if_ready, id_valid, id_inst, id_pc4, count, bubble_cnt
    );

    modport master (
        output if_valid, if_inst, if_pc4, flush, id_ready,
        input  if_ready, id_valid, id_inst, id_pc4, count, bubble_cnt
    );
`else
    modport slave (
        input  if_valid, if_inst, if_pc4, flush, id_ready,
        output if_ready, id_valid, id_inst, id_pc4, count
    );

    modport master (
        output if_valid, if_inst, if_pc4, flush, id_ready,
        input  if_ready, id_valid, id_inst, id_pc4, count
    );
`endif
endinterface

// File: rtl/pipe_ifid_queue.sv
// IF/ID decoupling queue: buffers {inst, pc4} from fetch and hands them to decode.
// Optional macro IFID_BUBBLE_CNT_EN adds a free-running decode-bubble counter.
module pipe_ifid_queue #(
    parameter int DEPTH = 2,
    parameter int AW    = 1
) (
    input  logic               clk,
    input  logic               rst,
    pipe_ifid_queue_if.slave   bus
);

    localparam logic [AW:0]   CNT_ZERO = (AW+1)'(0);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] PTR_ZERO = AW'(0);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    typedef enum logic [1:0] {
        OCC_EMPTY   = 2'd0,
        OCC_PARTIAL = 2'd1,
        OCC_FULL    = 2'd2
    } occ_e;

    logic [63:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wp;
    logic [AW-1:0] r_rp;
    logic [AW:0]   r_cnt;

    occ_e          w_occ;
    logic          w_push;
    logic          w_pop;
    logic          w_commit;
    logic [AW:0]   w_cnt_nxt;
    logic [63:0]   w_head;

    // Occupancy class derived from the registered count only, so if_ready never depends on id_ready.
    always_comb begin
        w_occ = OCC_PARTIAL;
        if (r_cnt == CNT_ZERO) begin
            w_occ = OCC_EMPTY;
        end else if (r_cnt == CNT_FULL) begin
            w_occ = OCC_FULL;
        end else begin
            w_occ = OCC_PARTIAL;
        end
    end

    // Handshake qualification; flush and reset suppress any state change this cycle.
    always_comb begin
        w_push   = bus.if_valid & (w_occ != OCC_FULL);
        w_pop    = bus.id_ready & (w_occ != OCC_EMPTY);
        w_commit = ~rst & ~bus.flush;
    end

    // Next occupancy: simultaneous push and pop leave the count unchanged.
    always_comb begin
        w_cnt_nxt = r_cnt;
        case ({w_push, w_pop})
            2'b10:   w_cnt_nxt = r_cnt + CNT_ONE;
            2'b01:   w_cnt_nxt = r_cnt - CNT_ONE;
            default: w_cnt_nxt = r_cnt;
        endcase
    end

    // Pointer and occupancy registers; reset outranks flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wp  <= PTR_ZERO;
            r_rp  <= PTR_ZERO;
            r_cnt <= CNT_ZERO;
        end else if (bus.flush) begin
            r_wp  <= PTR_ZERO;
            r_rp  <= PTR_ZERO;
            r_cnt <= CNT_ZERO;
        end else begin
            r_cnt <= w_cnt_nxt;
            if (w_push) begin
                r_wp <= r_wp + PTR_ONE;
            end else begin
                r_wp <= r_wp;
            end
            if (w_pop) begin
                r_rp <= r_rp + PTR_ONE;
            end else begin
                r_rp <= r_rp;
            end
        end
    end

    // Entry storage; contents are never cleared since empty reads are masked.
    always_ff @(posedge clk) begin
        if (w_push && w_commit) begin
            r_mem[r_wp] <= {bus.if_inst, bus.if_pc4};
        end else begin
            r_mem[r_wp] <= r_mem[r_wp];
        end
    end

    // Head entry presented to decode; an empty queue shows a nop with zero pc4.
    always_comb begin
        w_head = 64'h0;
        if (w_occ == OCC_EMPTY) begin
            w_head = 64'h0;
        end else begin
            w_head = r_mem[r_rp];
        end
    end

    assign bus.if_ready = (w_occ != OCC_FULL);
    assign bus.id_valid = (w_occ != OCC_EMPTY);
    assign bus.id_inst  = w_head[63:32];
    assign bus.id_pc4   = w_head[31:0];
    assign bus.count    = r_cnt;

`ifdef IFID_BUBBLE_CNT_EN
    logic [31:0] r_bubble;

    // Counts cycles where decode was ready but had nothing to take; flush does not clear it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bubble <= 32'h0;
        end else if (bus.id_ready && (w_occ == OCC_EMPTY)) begin
            r_bubble <= r_bubble + 32'h1;
        end else begin
            r_bubble <= r_bubble;
        end
    end

    assign bus.bubble_cnt = r_bubble;
`endif

endmodule

// File: tb/tb_pipe_ifid_queue.sv
// Scoreboard bench for pipe_ifid_queue: directed scenarios followed by random traffic.
module tb_pipe_ifid_queue;

    localparam int DEPTH = 2;
    localparam int AW    = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;

    pipe_ifid_queue_if #(.AW(AW)) bus ();

    pipe_ifid_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_err    = 0;

    logic [63:0] mq[$];
    logic [63:0] exp_q[$];
    logic [31:0] m_bubble = 32'h0;

    function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endfunction

    task automatic check_state();
        logic [63:0] head;
        head = (mq.size() != 0) ? mq[0] : 64'h0;
        chk("count",    64'(bus.count),    64'(mq.size()));
        chk("if_ready", 64'(bus.if_ready), 64'(mq.size() != DEPTH));
        chk("id_valid", 64'(bus.id_valid), 64'(mq.size() != 0));
        chk("id_inst",  64'(bus.id_inst),  64'(head[63:32]));
        chk("id_pc4",   64'(bus.id_pc4),   64'(head[31:0]));
`ifdef IFID_BUBBLE_CNT_EN
        chk("bubble_cnt", 64'(bus.bubble_cnt), 64'(m_bubble));
`endif
    endtask

    // One clock of stimulus: drive inputs, advance the reference queue, check after the edge.
    task automatic step(input logic r, input logic v, input logic [31:0] inst,
                        input logic [31:0] pc4, input logic fl, input logic rdy);
        int pre;
        rst          = r;
        bus.if_valid = v;
        bus.if_inst  = inst;
        bus.if_pc4   = pc4;
        bus.flush    = fl;
        bus.id_ready = rdy;
        pre = mq.size();
        if (r) begin
            mq.delete();
            m_bubble = 32'h0;
        end else begin
            if (rdy && pre == 0) m_bubble = m_bubble + 32'h1;
            if (fl) begin
                mq.delete();
            end else begin
                if (rdy && pre > 0) void'(mq.pop_front());
                if (v && pre < DEPTH) begin
                    mq.push_back({inst, pc4});
                    exp_q.push_back({inst, pc4});
                end
            end
        end
        @(posedge clk);
        #1;
        check_state();
    endtask

    // Monitor: every handshake pop must deliver the oldest outstanding entry.
    initial begin
        logic [63:0] e;
        forever begin
            @(negedge clk);
            if (rst || bus.flush) begin
                exp_q.delete();
            end else if (bus.id_valid === 1'b1 && bus.id_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_err++;
                    $display("FAIL pop_unexpected: got inst %h expected no entry", bus.id_inst);
                end else begin
                    e = exp_q.pop_front();
                    chk("pop_inst", 64'(bus.id_inst), 64'(e[63:32]));
                    chk("pop_pc4",  64'(bus.id_pc4),  64'(e[31:0]));
                end
            end
        end
    end

    initial begin
        bus.if_valid = 1'b0;
        bus.if_inst  = 32'h0;
        bus.if_pc4   = 32'h0;
        bus.flush    = 1'b0;
        bus.id_ready = 1'b0;

        // Reset for two cycles, then idle
        step(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        chk("reset_if_ready", 64'(bus.if_ready), 64'h1);

        // Single push visible after one edge, then drained
        step(1'b0, 1'b1, 32'h8C22_0004, 32'h4, 1'b0, 1'b0);
        chk("single_inst", 64'(bus.id_inst), 64'h8C22_0004);
        step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);

        // Fill to full, third push ignored, drain in order
        step(1'b0, 1'b1, 32'h0022_1820, 32'h8,  1'b0, 1'b0);
        step(1'b0, 1'b1, 32'h0000_0000, 32'hC,  1'b0, 1'b0);
        chk("full_if_ready", 64'(bus.if_ready), 64'h0);
        step(1'b0, 1'b1, 32'hDEAD_BEEF, 32'h10, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);

        // Steady stream: occupancy holds at one
        for (int i = 0; i < 8; i++)
            step(1'b0, 1'b1, 32'h1000 + 32'(i), 32'h20 + 32'(4 * i), 1'b0, 1'b1);
        chk("stream_count", 64'(bus.count), 64'h1);
        step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);

        // Flush while full with a push, and flush while partial with push and pop
        step(1'b0, 1'b1, 32'hAAAA_0001, 32'h40, 1'b0, 1'b0);
        step(1'b0, 1'b1, 32'hAAAA_0002, 32'h44, 1'b0, 1'b0);
        step(1'b0, 1'b1, 32'hAAAA_0003, 32'h48, 1'b1, 1'b0);
        chk("flush_valid", 64'(bus.id_valid), 64'h0);
        step(1'b0, 1'b1, 32'hBBBB_0001, 32'h50, 1'b0, 1'b0);
        step(1'b0, 1'b1, 32'hBBBB_0002, 32'h54, 1'b1, 1'b1);
        step(1'b0, 1'b1, 32'hCCCC_0001, 32'h58, 1'b0, 1'b0);
        step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);

`ifdef IFID_BUBBLE_CNT_EN
        // Bubble counter: five empty-ready cycles, survives flush, cleared by reset
        step(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        chk("bubble_five", 64'(bus.bubble_cnt), 64'h5);
        step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        chk("bubble_flush", 64'(bus.bubble_cnt), 64'h5);
        step(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        chk("bubble_rst", 64'(bus.bubble_cnt), 64'h0);
`endif

        // Random traffic with occasional flush and reset
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(63) == 0) ? 1'b1 : 1'b0,
                 1'($urandom_range(1)),
                 $urandom, $urandom,
                 ($urandom_range(15) == 0) ? 1'b1 : 1'b0,
                 1'($urandom_range(1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
